// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: default datapath width, divider FSM
// encoding and the quotient value reported for a divide by zero.
package arith_pkg;

  localparam int ARITH_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ARITH_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q_msb} left, trial
// subtract D through a WIDTH+1 ripple chain, keep the difference if no borrow.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic             o_q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub_b;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH+1:0] w_carry;
  logic             w_no_borrow;

  assign w_shift    = {i_r[WIDTH-1:0], i_q_msb};
  assign w_sub_b    = ~{1'b0, i_d};
  assign w_carry[0] = 1'b1;

  // Two's-complement subtract: carry out of the top cell set means no borrow.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_ripple
    fulladder u_fa (
      .i_a   (w_shift[i]),
      .i_b   (w_sub_b[i]),
      .i_cin (w_carry[i]),
      .o_sum (w_diff[i]),
      .o_cout(w_carry[i+1])
    );
  end

  // A set bit shifted out of R already exceeds any divisor.
  assign w_no_borrow = w_carry[WIDTH+1] | i_r[WIDTH];
  assign o_r         = w_no_borrow ? w_diff : w_shift;
  assign o_q_bit     = w_no_borrow;

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell, the ripple building block of the arithmetic unit.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle unsigned restoring divider with valid/ready ports on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
module seq_div32
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output state_t           o_dbg_state
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_last_step;
  logic [WIDTH:0]   w_step_r;
  logic             w_q_bit;

  assign w_accept    = in_valid && in_ready;
  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r    (r_r),
    .i_q_msb(r_q[WIDTH-1]),
    .i_d    (r_d),
    .o_r    (w_step_r),
    .o_q_bit(w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last_step) w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE);
    out_valid   = (r_state == ST_DONE);
    o_dbg_state = r_state;
  end

  // Result registers are only written on accept or a RUN step, so they hold
  // through DONE back-pressure and keep the last result in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_d   <= divisor;
      if (divisor == '0) begin
        r_q        <= {WIDTH{DIV0_QUOTIENT[0]}};
        r_r        <= {1'b0, dividend};
        r_div_zero <= 1'b1;
      end else begin
        r_q        <= dividend;
        r_r        <= '0;
        r_div_zero <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      r_r   <= w_step_r;
      r_q   <= {r_q[WIDTH-2:0], w_q_bit};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign quotient  = r_q;
  assign remainder = r_r[WIDTH-1:0];
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed scenarios plus a randomized
// regression scored against plain '/' and '%' arithmetic.
module tb_seq_div32;
  import arith_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  seq_div32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {quotient, remainder}
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {{W{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  // driver tasks (called at a falling edge with in_ready high)
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // edges counted including the accept edge; -1 on timeout
  task automatic wait_valid(output int edges);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (out_valid !== 1'b1) edges = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges;
    out_ready = 1'b1;
    start_op(32'd100, 32'd7);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy: in_ready got %b want 0", in_ready); end
    wait_valid(edges);
    checks++; if (edges != 33) begin errors++; $display("FAIL basic_latency: got %0d want 33", edges); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_div_zero: got %b want 0", div_zero); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd12345, 32'h8000_0000, 32'd7};
    logic [W-1:0] tb [7] = '{32'd1, 32'hFFFF_FFFF, 32'd9, 32'd7, 32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [2*W-1:0] e;
    int edges;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      e = ref_div(ta[i], tb[i]);
      start_op(ta[i], tb[i]);
      wait_valid(edges);
      checks++; if (edges != 33) begin errors++; $display("FAIL bound_latency[%0d]: got %0d want 33", i, edges); end
      checks++; if (quotient !== e[2*W-1:W] || remainder !== e[W-1:0]) begin
        errors++; $display("FAIL bound_result[%0d] %h/%h: got %h r %h want %h r %h",
                           i, ta[i], tb[i], quotient, remainder, e[2*W-1:W], e[W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    int edges;
    out_ready = 1'b1;
    start_op(32'd5, 32'd0);
    wait_valid(edges);
    checks++; if (edges != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", edges); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient: got %h want ffffffff", quotient); end
    checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL dz_remainder: got %0d want 5", remainder); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_zero); end
    @(negedge clk);
    checks++; if (div_zero !== 1'b1 || quotient !== 32'hFFFF_FFFF || in_ready !== 1'b1) begin
      errors++; $display("FAIL dz_retain: div_zero=%b quotient=%h in_ready=%b want 1/ffffffff/1", div_zero, quotient, in_ready);
    end
    start_op(32'd3, 32'd10);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_on_accept: got %b want 0", div_zero); end
    wait_valid(edges);
    checks++; if (edges != 33) begin errors++; $display("FAIL dz_next_latency: got %0d want 33", edges); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd3) begin
      errors++; $display("FAIL dz_next_result: got %0d r %0d want 0 r 3", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int edges;
    out_ready = 1'b0;
    start_op(32'd1000, 32'd3);
    wait_valid(edges);
    checks++; if (edges != 33) begin errors++; $display("FAIL bp_latency: got %0d want 33", edges); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_flags[%0d]: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
      end
      checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin
        errors++; $display("FAIL bp_hold_result[%0d]: got %0d r %0d want 333 r 1", i, quotient, remainder);
      end
      in_valid = ($urandom_range(0, 1) == 1);
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++; if (quotient !== 32'd333 || remainder !== 32'd1) begin
      errors++; $display("FAIL bp_retain: got %0d r %0d want 333 r 1", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    out_ready = 1'b1;
    start_op(32'd77, 32'd5);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++; if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: q=%h r=%h dz=%b want 0/0/0", quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result: out_valid got %b want 0", out_valid); end
    start_op(32'd77, 32'd5);
    wait_valid(edges);
    checks++; if (edges != 33) begin errors++; $display("FAIL midrst_latency: got %0d want 33", edges); end
    checks++; if (quotient !== 32'd15 || remainder !== 32'd2) begin
      errors++; $display("FAIL midrst_result: got %0d r %0d want 15 r 2", quotient, remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] e;
    logic [2*W-1:0] recon;
    bit             got;
    for (int n = 0; n < 1200; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 16));
        2:       b = a;
        3:       b = a >> $urandom_range(1, 31);
        4:       b = a + 1'b1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      exp_q.push_back(ref_div(a, b));
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(a, b);
      got = 1'b0;
      for (int c = 0; c < 150 && !got; c++) begin
        if (out_valid === 1'b1) begin
          e = exp_q[0];
          checks++; if (quotient !== e[2*W-1:W] || remainder !== e[W-1:0] || div_zero !== (b == '0)) begin
            errors++; $display("FAIL rand_result[%0d] %h/%h: got %h r %h dz %b want %h r %h dz %b",
                               n, a, b, quotient, remainder, div_zero, e[2*W-1:W], e[W-1:0], (b == '0));
          end
          if (b != '0) begin
            recon = 64'(quotient) * 64'(b) + 64'(remainder);
            checks++; if (recon !== 64'(a) || remainder >= b) begin
              errors++; $display("FAIL rand_identity[%0d] %h/%h: q*d+r=%h r=%h want %h and r<d", n, a, b, recon, remainder, a);
            end
          end
          out_ready = ($urandom_range(0, 2) != 0);
          got = out_ready;
        end else begin
          out_ready = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
      end
      void'(exp_q.pop_front());
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_timeout[%0d] %h/%h: no result within 150 cycles", n, a, b);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
